// File: rtl/gdb_rsp_pkg.sv
// Shared definitions for the GDB Remote Serial Protocol receive/transmit blocks:
// framing characters, receiver state encoding and ASCII hex decode.
package gdb_rsp_pkg;

   localparam logic [7:0] CH_SOP  = 8'h24;  // '$'
   localparam logic [7:0] CH_EOP  = 8'h23;  // '#'
   localparam logic [7:0] CH_ESC  = 8'h7D;  // '}'
   localparam logic [7:0] CH_BRK  = 8'h03;  // ctrl-C
   localparam logic [7:0] CH_ACK  = 8'h2B;  // '+'
   localparam logic [7:0] CH_NAK  = 8'h2D;  // '-'
   localparam logic [7:0] ESC_XOR = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_ESC,
      ST_CS_HI,
      ST_CS_LO,
      ST_STS,
      ST_ACK
   } rsp_state_t;

   // Returns {valid, nibble}; valid is 0 for anything outside 0-9, a-f, A-F.
   function automatic logic [4:0] hex2nib(input logic [7:0] c);
      logic [4:0] r;
      r = 5'd0;
      if (c >= 8'h30 && c <= 8'h39)
         r = {1'b1, c[3:0]};
      else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46))
         r = {1'b1, c[3:0] + 4'd9};
      return r;
   endfunction

endpackage

// File: rtl/gdb_rsp_hex2nib.sv
// Combinational ASCII hex digit decode with a valid flag.
module gdb_rsp_hex2nib
   import gdb_rsp_pkg::*;
(
   input  logic [7:0] chr,
   output logic [3:0] nib,
   output logic       vld
);

   // Decode one character.
   always_comb begin
      {vld, nib} = hex2nib(chr);
   end

endmodule

// File: rtl/gdb_rsp_rx.sv
// GDB RSP packet receiver: frames $payload#cs, un-escapes the payload,
// checks the mod-256 checksum and reports per-packet status.
// Define GDB_RSP_RX_ACK_EN to emit the '+'/'-' acknowledgement byte.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | between packets; waits for '$', flags ctrl-C as brk
// DATA     | payload bytes; '#' ends, '}' escapes, '$' restarts
// ESC      | next byte is forwarded XOR 0x20
// CS_HI    | first checksum hex digit
// CS_LO    | second checksum hex digit
// STS      | status offered once the payload register has drained
// ACK      | '+'/'-' offered (ack build only)
module gdb_rsp_rx
   import gdb_rsp_pkg::*;
#(
   parameter  int PAYLOAD_MAX = 1024,
   localparam int LW          = $clog2(PAYLOAD_MAX + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rx_vld,
   input  logic [7:0]    rx_dat,
   output logic          rx_rdy,
   output logic          pay_vld,
   output logic [7:0]    pay_dat,
   input  logic          pay_rdy,
   output logic          sts_vld,
   input  logic          sts_rdy,
   output logic          sts_ok,
   output logic          sts_ovf,
   output logic [LW-1:0] sts_len,
   output logic          ack_vld,
   output logic [7:0]    ack_dat,
   input  logic          ack_rdy,
   output logic          brk
);

   localparam logic [LW-1:0] LEN_MAX = LW'(PAYLOAD_MAX);

   rsp_state_t    state, state_nxt;
   logic          rdy_int;
   logic          acc;
   logic          clr;
   logic          add;
   logic          fwd;
   logic [7:0]    fwd_dat;
   logic [7:0]    sum;
   logic [LW-1:0] len;
   logic          ovf;
   logic [3:0]    cs_hi;
   logic          cs_bad;
   logic          ok_q;
   logic          pay_vld_q;
   logic [7:0]    pay_dat_q;
   logic          brk_q;
   logic [3:0]    nib;
   logic          nib_vld;

   gdb_rsp_hex2nib u_hex (
      .chr (rx_dat),
      .nib (nib),
      .vld (nib_vld)
   );

   assign rx_rdy  = rst_n & rdy_int;
   assign acc     = rx_vld & rx_rdy;
   assign pay_vld = pay_vld_q;
   assign pay_dat = pay_dat_q;
   assign sts_ok  = ok_q;
   assign sts_ovf = ovf;
   assign sts_len = len;
   assign brk     = brk_q;

`ifndef GDB_RSP_RX_ACK_EN
   logic unused_ack_rdy;
   assign unused_ack_rdy = ack_rdy;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state, handshake outputs and datapath strobes.
   always_comb begin
      state_nxt = state;
      rdy_int   = 1'b0;
      sts_vld   = 1'b0;
      ack_vld   = 1'b0;
      ack_dat   = CH_ACK;
      clr       = 1'b0;
      add       = 1'b0;
      fwd       = 1'b0;
      fwd_dat   = rx_dat;
      unique case (state)
         ST_IDLE: begin
            rdy_int = 1'b1;
            if (acc && rx_dat == CH_SOP) begin
               clr       = 1'b1;
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            rdy_int = !pay_vld_q || pay_rdy;
            if (acc) begin
               if (rx_dat == CH_EOP) begin
                  state_nxt = ST_CS_HI;
               end else if (rx_dat == CH_SOP) begin
                  clr = 1'b1;
               end else if (rx_dat == CH_ESC) begin
                  add       = 1'b1;
                  state_nxt = ST_ESC;
               end else begin
                  add = 1'b1;
                  fwd = 1'b1;
               end
            end
         end
         ST_ESC: begin
            rdy_int = !pay_vld_q || pay_rdy;
            fwd_dat = rx_dat ^ ESC_XOR;
            if (acc) begin
               add       = 1'b1;
               fwd       = 1'b1;
               state_nxt = ST_DATA;
            end
         end
         ST_CS_HI: begin
            rdy_int = 1'b1;
            if (acc) state_nxt = ST_CS_LO;
         end
         ST_CS_LO: begin
            rdy_int = 1'b1;
            if (acc) state_nxt = ST_STS;
         end
         ST_STS: begin
            // Status must not overtake the last payload byte.
            sts_vld = !pay_vld_q;
            if (sts_vld && sts_rdy) begin
`ifdef GDB_RSP_RX_ACK_EN
               state_nxt = ST_ACK;
`else
               state_nxt = ST_IDLE;
`endif
            end
         end
         ST_ACK: begin
`ifdef GDB_RSP_RX_ACK_EN
            ack_vld = 1'b1;
            ack_dat = ok_q ? CH_ACK : CH_NAK;
            if (ack_rdy) state_nxt = ST_IDLE;
`else
            state_nxt = ST_IDLE;
`endif
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Checksum, length, overflow, payload stage and break pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum       <= 8'd0;
         len       <= '0;
         ovf       <= 1'b0;
         cs_hi     <= 4'd0;
         cs_bad    <= 1'b0;
         ok_q      <= 1'b0;
         pay_vld_q <= 1'b0;
         pay_dat_q <= 8'd0;
         brk_q     <= 1'b0;
      end else begin
         brk_q <= (state == ST_IDLE) && acc && (rx_dat == CH_BRK);

         if (clr) begin
            sum    <= 8'd0;
            len    <= '0;
            ovf    <= 1'b0;
            cs_bad <= 1'b0;
            ok_q   <= 1'b0;
         end else if (add) begin
            sum <= sum + rx_dat;
         end

         if (pay_vld_q && pay_rdy)
            pay_vld_q <= 1'b0;

         if (fwd) begin
            if (len == LEN_MAX) begin
               ovf <= 1'b1;
            end else begin
               len       <= len + LW'(1);
               pay_vld_q <= 1'b1;
               pay_dat_q <= fwd_dat;
            end
         end

         if (state == ST_CS_HI && acc) begin
            cs_hi  <= nib;
            cs_bad <= !nib_vld;
         end

         if (state == ST_CS_LO && acc)
            ok_q <= nib_vld && !cs_bad && !ovf && ({cs_hi, nib} == sum);
      end
   end

endmodule

// File: tb/tb_gdb_rsp_rx.sv
// Directed bench for gdb_rsp_rx, built with PAYLOAD_MAX=4 so the overflow
// boundary is reachable with short packets.
module tb_gdb_rsp_rx;

   localparam int PM  = 4;
   localparam int LWB = $clog2(PM + 1);

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           rx_vld = 1'b0;
   logic [7:0]     rx_dat = 8'h00;
   logic           rx_rdy;
   logic           pay_vld;
   logic [7:0]     pay_dat;
   logic           pay_rdy = 1'b1;
   logic           sts_vld;
   logic           sts_rdy = 1'b1;
   logic           sts_ok;
   logic           sts_ovf;
   logic [LWB-1:0] sts_len;
   logic           ack_vld;
   logic [7:0]     ack_dat;
   logic           ack_rdy = 1'b1;
   logic           brk;

   int n_tests = 0;
   int n_fail  = 0;
   bit stall    = 1'b0;
   bit hold_pay = 1'b0;
   int brk_cnt  = 0;
   int ack_cyc  = 0;

   logic [7:0]     pay_q[$];
   logic [LWB+1:0] sts_q[$];
   logic [7:0]     ack_q[$];

   gdb_rsp_rx #(.PAYLOAD_MAX(PM)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx_vld  (rx_vld),
      .rx_dat  (rx_dat),
      .rx_rdy  (rx_rdy),
      .pay_vld (pay_vld),
      .pay_dat (pay_dat),
      .pay_rdy (pay_rdy),
      .sts_vld (sts_vld),
      .sts_rdy (sts_rdy),
      .sts_ok  (sts_ok),
      .sts_ovf (sts_ovf),
      .sts_len (sts_len),
      .ack_vld (ack_vld),
      .ack_dat (ack_dat),
      .ack_rdy (ack_rdy),
      .brk     (brk)
   );

   always #5 clk = ~clk;

   // Downstream ready generators, updated just after each rising edge.
   always @(posedge clk) begin
      #1;
      pay_rdy = hold_pay ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
      sts_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      ack_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Mid-cycle monitor: values here are what the next rising edge will see.
   always @(negedge clk) begin
      if (rst_n) begin
         if (pay_vld && pay_rdy) pay_q.push_back(pay_dat);
         if (sts_vld && sts_rdy) sts_q.push_back({sts_ok, sts_ovf, sts_len});
         if (ack_vld && ack_rdy) ack_q.push_back(ack_dat);
         if (brk) brk_cnt++;
         if (ack_vld) ack_cyc++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      rx_vld = 1'b1;
      rx_dat = b;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (rx_rdy) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      rx_vld = 1'b0;
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_byte: byte %02h rx_rdy=0 for 200 cycles, required 1", b);
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Collects one packet's status (and ack), draining the payload queue.
   task automatic get_pkt(output logic ok, output logic ovf, output logic [LWB-1:0] len,
                          output string pay, output logic [7:0] ack, output bit got);
      logic [LWB+1:0] r;
      got = 1'b0;
      ok  = 1'b0;
      ovf = 1'b0;
      len = '0;
      pay = "";
      ack = 8'h00;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         #2;
`ifdef GDB_RSP_RX_ACK_EN
         if (sts_q.size() > 0 && ack_q.size() > 0) begin
`else
         if (sts_q.size() > 0) begin
`endif
            got = 1'b1;
            break;
         end
      end
      if (got) begin
         r = sts_q.pop_front();
         {ok, ovf, len} = r;
         foreach (pay_q[i]) pay = $sformatf("%s%c", pay, pay_q[i]);
         pay_q.delete();
`ifdef GDB_RSP_RX_ACK_EN
         ack = ack_q.pop_front();
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      idle_cycles(3);
      @(negedge clk);
      n_tests++;
      if ({rx_rdy, pay_vld, pay_dat, sts_vld, sts_ok, sts_ovf, sts_len, ack_vld, brk} !== '0) begin
         n_fail++;
         $display("FAIL reset_zero: rx_rdy=%b pay_vld=%b pay_dat=%h sts_vld=%b ok=%b ovf=%b len=%0d ack_vld=%b brk=%b, required all 0",
                  rx_rdy, pay_vld, pay_dat, sts_vld, sts_ok, sts_ovf, sts_len, ack_vld, brk);
      end
      n_tests++;
      if (ack_dat !== 8'h2B) begin
         n_fail++;
         $display("FAIL reset_ack_dat: got %h required 2b", ack_dat);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (rx_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_rx_rdy: got %b required 1", rx_rdy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_checksum;
      string    vec[5]  = '{"$g#67", "$m0,4#fd", "$m0,4#FD", "$g#68", "$g#6z"};
      string    epay[5] = '{"g", "m0,4", "m0,4", "g", "g"};
      bit       eok[5]  = '{1, 1, 1, 0, 0};
      int       elen[5] = '{1, 4, 4, 1, 1};
      logic ok, ovf;
      logic [LWB-1:0] len;
      logic [7:0] ack;
      string pay;
      bit got;
      for (int k = 0; k < 5; k++) begin
         send_str(vec[k]);
         get_pkt(ok, ovf, len, pay, ack, got);
         n_tests++;
         if (!got || ok !== eok[k] || ovf !== 1'b0 || len !== LWB'(elen[k]) || pay != epay[k]) begin
            n_fail++;
            $display("FAIL csum %s: got=%0b ok=%b ovf=%b len=%0d pay=\"%s\", required ok=%b ovf=0 len=%0d pay=\"%s\"",
                     vec[k], got, ok, ovf, len, pay, eok[k], elen[k], epay[k]);
         end
`ifdef GDB_RSP_RX_ACK_EN
         n_tests++;
         if (ack !== (eok[k] ? 8'h2B : 8'h2D)) begin
            n_fail++;
            $display("FAIL csum_ack %s: got %h required %h", vec[k], ack, eok[k] ? 8'h2B : 8'h2D);
         end
`else
         n_tests++;
         if (ack_cyc != 0 || ack_dat !== 8'h2B) begin
            n_fail++;
            $display("FAIL csum_noack %s: ack_vld cycles=%0d ack_dat=%h, required 0 and 2b", vec[k], ack_cyc, ack_dat);
         end
`endif
      end
   endtask

   task automatic test_escape;
      string s, e1, v2, e2;
      logic ok, ovf;
      logic [LWB-1:0] len;
      logic [7:0] ack;
      string pay;
      bit got;
      int b0;
      b0 = brk_cnt;
      s = "$X}?#d8";
      s[3] = 8'h03;
      e1 = "X#";
      send_str(s);
      get_pkt(ok, ovf, len, pay, ack, got);
      n_tests++;
      if (!got || ok !== 1'b1 || ovf !== 1'b0 || len !== LWB'(2) || pay != e1) begin
         n_fail++;
         $display("FAIL escape: got=%0b ok=%b ovf=%b len=%0d pay=\"%s\", required ok=1 ovf=0 len=2 pay=\"X#\"",
                  got, ok, ovf, len, pay);
      end
      v2 = "$?#03";
      v2[1] = 8'h03;
      e2 = "?";
      e2[0] = 8'h03;
      send_str(v2);
      get_pkt(ok, ovf, len, pay, ack, got);
      n_tests++;
      if (!got || ok !== 1'b1 || len !== LWB'(1) || pay != e2 || brk_cnt != b0) begin
         n_fail++;
         $display("FAIL ctrlc_in_packet: got=%0b ok=%b len=%0d paylen=%0d brk_pulses=%0d, required ok=1 len=1 paylen=1 brk_pulses=%0d",
                  got, ok, len, pay.len(), brk_cnt, b0);
      end
   endtask

   task automatic test_brk;
      int b0;
      b0 = brk_cnt;
      send_byte(8'h03);
      idle_cycles(6);
      n_tests++;
      if (brk_cnt != b0 + 1 || pay_q.size() != 0 || sts_q.size() != 0) begin
         n_fail++;
         $display("FAIL brk: pulses=%0d pay=%0d sts=%0d, required pulses=1 pay=0 sts=0",
                  brk_cnt - b0, pay_q.size(), sts_q.size());
      end
      send_str("+-x");
      idle_cycles(4);
      n_tests++;
      if (brk_cnt != b0 + 1 || pay_q.size() != 0 || sts_q.size() != 0) begin
         n_fail++;
         $display("FAIL idle_drop: pulses=%0d pay=%0d sts=%0d, required pulses=1 pay=0 sts=0",
                  brk_cnt - b0, pay_q.size(), sts_q.size());
      end
   endtask

   task automatic test_overflow;
      string vec[3]  = '{"$abcdef#55", "$abcd#8a", "$#00"};
      string epay[3] = '{"abcd", "abcd", ""};
      bit    eok[3]  = '{0, 1, 1};
      bit    eovf[3] = '{1, 0, 0};
      int    elen[3] = '{4, 4, 0};
      logic ok, ovf;
      logic [LWB-1:0] len;
      logic [7:0] ack;
      string pay;
      bit got;
      for (int k = 0; k < 3; k++) begin
         send_str(vec[k]);
         get_pkt(ok, ovf, len, pay, ack, got);
         n_tests++;
         if (!got || ok !== eok[k] || ovf !== eovf[k] || len !== LWB'(elen[k]) || pay != epay[k]) begin
            n_fail++;
            $display("FAIL ovf %s: got=%0b ok=%b ovf=%b len=%0d pay=\"%s\", required ok=%b ovf=%b len=%0d pay=\"%s\"",
                     vec[k], got, ok, ovf, len, pay, eok[k], eovf[k], elen[k], epay[k]);
         end
`ifdef GDB_RSP_RX_ACK_EN
         n_tests++;
         if (ack !== (eok[k] ? 8'h2B : 8'h2D)) begin
            n_fail++;
            $display("FAIL ovf_ack %s: got %h required %h", vec[k], ack, eok[k] ? 8'h2B : 8'h2D);
         end
`endif
      end
   endtask

   task automatic test_stall_reset;
      logic ok, ovf;
      logic [LWB-1:0] len;
      logic [7:0] ack;
      string pay;
      bit got;
      stall = 1'b1;
      send_str("$m0,4#fd");
      get_pkt(ok, ovf, len, pay, ack, got);
      n_tests++;
      if (!got || ok !== 1'b1 || len !== LWB'(4) || pay != "m0,4") begin
         n_fail++;
         $display("FAIL stall_pkt: got=%0b ok=%b len=%0d pay=\"%s\", required ok=1 len=4 pay=\"m0,4\"",
                  got, ok, len, pay);
      end
      hold_pay = 1'b1;
      idle_cycles(1);
      send_str("$a");
      idle_cycles(2);
      n_tests++;
      if (pay_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL held_pay: pay_vld=%b required 1", pay_vld);
      end
      rst_n = 1'b0;
      idle_cycles(1);
      @(negedge clk);
      n_tests++;
      if ({rx_rdy, pay_vld, pay_dat, sts_vld, sts_ok, sts_ovf, sts_len, ack_vld, brk} !== '0 || ack_dat !== 8'h2B) begin
         n_fail++;
         $display("FAIL midpkt_reset: rx_rdy=%b pay_vld=%b pay_dat=%h sts_vld=%b ok=%b len=%0d ack_vld=%b ack_dat=%h, required zeros and ack_dat 2b",
                  rx_rdy, pay_vld, pay_dat, sts_vld, sts_ok, sts_len, ack_vld, ack_dat);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      hold_pay = 1'b0;
      idle_cycles(8);
      n_tests++;
      if (pay_q.size() != 0 || sts_q.size() != 0) begin
         n_fail++;
         $display("FAIL reset_discard: pay=%0d sts=%0d, required 0 and 0", pay_q.size(), sts_q.size());
      end
      send_str("$g#67");
      get_pkt(ok, ovf, len, pay, ack, got);
      n_tests++;
      if (!got || ok !== 1'b1 || ovf !== 1'b0 || len !== LWB'(1) || pay != "g") begin
         n_fail++;
         $display("FAIL post_reset_pkt: got=%0b ok=%b ovf=%b len=%0d pay=\"%s\", required ok=1 ovf=0 len=1 pay=\"g\"",
                  got, ok, ovf, len, pay);
      end
      // Bytes of the abandoned packet were already forwarded; only g gets a status.
      send_str("$ab$g#67");
      get_pkt(ok, ovf, len, pay, ack, got);
      idle_cycles(10);
      n_tests++;
      if (!got || ok !== 1'b1 || len !== LWB'(1) || pay != "abg" || sts_q.size() != 0) begin
         n_fail++;
         $display("FAIL resync: got=%0b ok=%b len=%0d pay=\"%s\" extra_sts=%0d, required ok=1 len=1 pay=\"abg\" extra_sts=0",
                  got, ok, len, pay, sts_q.size());
      end
`ifdef GDB_RSP_RX_ACK_EN
      n_tests++;
      if (ack !== 8'h2B || ack_q.size() != 0) begin
         n_fail++;
         $display("FAIL resync_ack: got %h extra=%0d, required 2b extra=0", ack, ack_q.size());
      end
`else
      n_tests++;
      if (ack_cyc != 0) begin
         n_fail++;
         $display("FAIL noack_stall: ack_vld cycles=%0d required 0", ack_cyc);
      end
`endif
      stall = 1'b0;
   endtask

   initial begin
      test_reset();
      test_checksum();
      test_escape();
      test_brk();
      test_overflow();
      test_stall_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
